// File: rtl/flag_hazard_ctrl_pkg.sv
// Shared condition codes, flag-group indices and the
// condition-to-flag-group read decoder.
package flag_hazard_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLG_NZ = 1;
  localparam int FLG_CV = 0;

  typedef struct packed {
    logic nz;
    logic cv;
  } grp_t;

  function automatic grp_t cond_reads(
    input logic [3:0] c
  );
    grp_t r;
    r = '0;
    unique case (1'b1)
      (c == COND_EQ || c == COND_NE ||
       c == COND_MI || c == COND_PL): begin
        r.nz = 1'b1;
      end
      (c == COND_CS || c == COND_CC ||
       c == COND_VS || c == COND_VC): begin
        r.cv = 1'b1;
      end
      (c == COND_HI || c == COND_LS ||
       c == COND_GE || c == COND_LT ||
       c == COND_GT || c == COND_LE): begin
        r.nz = 1'b1;
        r.cv = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_hazard_ctrl_if.sv
// Decode / writeback bundle between the pipeline
// and the flag hazard controller.
interface flag_hazard_ctrl_if #(
  parameter int MAX_PEND = 3
);
  localparam int W = $clog2(MAX_PEND + 1);

  logic         dec_valid;
  logic [3:0]   dec_cond;
  logic [1:0]   dec_flagw;
  logic         flush;
  logic         wb_valid;
  logic [1:0]   wb_flagw;
  logic         wb_condex;
  logic [3:0]   wb_flags;
  logic         stall_d;
  logic         issue_d;
  logic [3:0]   flags;
  logic [3:0]   flags_fwd;
  logic [W-1:0] pend_nz;
  logic [W-1:0] pend_cv;
  logic         pend_err;

  modport master (
    output dec_valid, dec_cond, dec_flagw,
    output flush,
    output wb_valid, wb_flagw,
    output wb_condex, wb_flags,
    input  stall_d, issue_d,
    input  flags, flags_fwd,
    input  pend_nz, pend_cv, pend_err
  );

  modport slave (
    input  dec_valid, dec_cond, dec_flagw,
    input  flush,
    input  wb_valid, wb_flagw,
    input  wb_condex, wb_flags,
    output stall_d, issue_d,
    output flags, flags_fwd,
    output pend_nz, pend_cv, pend_err
  );

endinterface

// File: rtl/flag_pend_ctr.sv
// In-flight writer counter for one flag group:
// saturating up/down with flush and sticky underflow.
module flag_pend_ctr #(
  parameter int MAX_PEND = 3,
  parameter int W = $clog2(MAX_PEND + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] eff,
  output logic         full,
  output logic         err
);

  localparam logic [W-1:0] MAXV = W'(MAX_PEND);

  // eff clamps at zero so a stray retire never
  // looks like a full counter
  always_comb begin
    eff = cnt;
    if (dec && cnt != '0) eff = cnt - W'(1);
  end

  assign full = (eff == MAXV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (dec && cnt == '0) err <= 1'b1;
      if (flush) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        if (cnt != MAXV) cnt <= cnt + W'(1);
      end else if (dec && !inc) begin
        if (cnt != '0) cnt <= cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// NZCV owner: stalls decode on pending flag groups,
// retires writeback updates and forwards them.
module flag_hazard_ctrl
  import flag_hazard_ctrl_pkg::*;
#(
  parameter int MAX_PEND = 3
) (
  input  logic clk,
  input  logic reset_n,
  flag_hazard_ctrl_if.slave bus
);

  localparam int W = $clog2(MAX_PEND + 1);

  grp_t         rd;
  logic         inc_nz, inc_cv;
  logic         dec_nz, dec_cv;
  logic [W-1:0] cnt_nz, cnt_cv;
  logic [W-1:0] eff_nz, eff_cv;
  logic         full_nz, full_cv;
  logic         err_nz, err_cv;
  logic         upd;
  logic [3:0]   flags_q;
  logic [3:0]   fwd;
  logic         stall;

  assign rd = cond_reads(bus.dec_cond);

  assign dec_nz = bus.wb_valid & bus.wb_flagw[FLG_NZ];
  assign dec_cv = bus.wb_valid & bus.wb_flagw[FLG_CV];
  assign inc_nz = bus.issue_d & bus.dec_flagw[FLG_NZ];
  assign inc_cv = bus.issue_d & bus.dec_flagw[FLG_CV];

  flag_pend_ctr #(.MAX_PEND(MAX_PEND), .W(W)) u_nz (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.flush),
    .inc     (inc_nz),
    .dec     (dec_nz),
    .cnt     (cnt_nz),
    .eff     (eff_nz),
    .full    (full_nz),
    .err     (err_nz)
  );

  flag_pend_ctr #(.MAX_PEND(MAX_PEND), .W(W)) u_cv (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.flush),
    .inc     (inc_cv),
    .dec     (dec_cv),
    .cnt     (cnt_cv),
    .eff     (eff_cv),
    .full    (full_cv),
    .err     (err_cv)
  );

  // a writer retiring this cycle is bypassed, so
  // only the effective counts gate decode
  always_comb begin
    stall = 1'b0;
    if (bus.dec_valid && !bus.flush) begin
      stall = (rd.nz && eff_nz != '0)
            | (rd.cv && eff_cv != '0)
            | (bus.dec_flagw[FLG_NZ] && full_nz)
            | (bus.dec_flagw[FLG_CV] && full_cv);
    end
  end

  assign upd = bus.wb_valid & bus.wb_condex;

  always_comb begin
    fwd = flags_q;
    if (upd && bus.wb_flagw[FLG_NZ])
      fwd[3:2] = bus.wb_flags[3:2];
    if (upd && bus.wb_flagw[FLG_CV])
      fwd[1:0] = bus.wb_flags[1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= 4'b0000;
    else          flags_q <= fwd;
  end

  assign bus.stall_d   = stall;
  assign bus.issue_d   = bus.dec_valid & ~stall
                       & ~bus.flush;
  assign bus.flags     = flags_q;
  assign bus.flags_fwd = fwd;
  assign bus.pend_nz   = cnt_nz;
  assign bus.pend_cv   = cnt_cv;
  assign bus.pend_err  = err_nz | err_cv;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl: stalls,
// bypass, saturation, flush and underflow.
module tb_flag_hazard_ctrl;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  flag_hazard_ctrl_if #(.MAX_PEND(3)) bus ();

  flag_hazard_ctrl #(.MAX_PEND(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid = 1'b0;
    bus.dec_cond  = 4'b1110;
    bus.dec_flagw = 2'b00;
    bus.flush     = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_flagw  = 2'b00;
    bus.wb_condex = 1'b0;
    bus.wb_flags  = 4'b0000;
  endtask

  task automatic dec(
    input logic [3:0] c,
    input logic [1:0] fw
  );
    bus.dec_valid = 1'b1;
    bus.dec_cond  = c;
    bus.dec_flagw = fw;
  endtask

  task automatic wb(
    input logic [1:0] fw,
    input logic       cx,
    input logic [3:0] f
  );
    bus.wb_valid  = 1'b1;
    bus.wb_flagw  = fw;
    bus.wb_condex = cx;
    bus.wb_flags  = f;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset_n = 1'b0;
    dec(4'b0000, 2'b00);
    #3;
    chk("rst_flags", 32'(bus.flags), 0);
    chk("rst_pnz", 32'(bus.pend_nz), 0);
    chk("rst_pcv", 32'(bus.pend_cv), 0);
    chk("rst_stall", 32'(bus.stall_d), 0);
    chk("rst_issue", 32'(bus.issue_d), 1);
    chk("rst_err", 32'(bus.pend_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // CMP then BEQ
    idle();
    dec(4'b1110, 2'b11);
    #1 chk("cmp_issue", 32'(bus.issue_d), 1);
    step();
    chk("cmp_pnz", 32'(bus.pend_nz), 1);
    chk("cmp_pcv", 32'(bus.pend_cv), 1);
    idle();
    dec(4'b0000, 2'b00);
    #1 chk("beq_stall", 32'(bus.stall_d), 1);
    chk("beq_noiss", 32'(bus.issue_d), 0);
    step();
    chk("beq_stall2", 32'(bus.stall_d), 1);
    wb(2'b11, 1'b1, 4'b0100);
    #1 chk("byp_stall", 32'(bus.stall_d), 0);
    chk("byp_issue", 32'(bus.issue_d), 1);
    chk("byp_fwd", 32'(bus.flags_fwd), 4'b0100);
    chk("byp_flg_old", 32'(bus.flags), 0);
    step();
    chk("byp_flags", 32'(bus.flags), 4'b0100);
    chk("byp_pnz", 32'(bus.pend_nz), 0);
    chk("byp_pcv", 32'(bus.pend_cv), 0);

    // ADDS (NZ only), BCS, BHI
    idle();
    dec(4'b1110, 2'b10);
    step();
    chk("adds_pnz", 32'(bus.pend_nz), 1);
    chk("adds_pcv", 32'(bus.pend_cv), 0);
    dec(4'b0010, 2'b00);
    #1 chk("bcs_stall", 32'(bus.stall_d), 0);
    chk("bcs_issue", 32'(bus.issue_d), 1);
    step();
    dec(4'b1000, 2'b00);
    #1 chk("bhi_stall", 32'(bus.stall_d), 1);
    step();
    wb(2'b10, 1'b1, 4'b1000);
    #1 chk("bhi_byp", 32'(bus.stall_d), 0);
    chk("bhi_fwd", 32'(bus.flags_fwd), 4'b1000);
    step();
    chk("bhi_flags", 32'(bus.flags), 4'b1000);
    chk("bhi_pnz", 32'(bus.pend_nz), 0);

    // saturation at MAX_PEND
    idle();
    dec(4'b1110, 2'b10);
    for (int i = 0; i < 3; i++) step();
    chk("sat_pnz", 32'(bus.pend_nz), 3);
    #1 chk("sat_stall", 32'(bus.stall_d), 1);
    chk("sat_noiss", 32'(bus.issue_d), 0);
    step();
    chk("sat_hold", 32'(bus.pend_nz), 3);
    wb(2'b10, 1'b1, 4'b0100);
    #1 chk("sat_wbstl", 32'(bus.stall_d), 0);
    chk("sat_wbiss", 32'(bus.issue_d), 1);
    step();
    chk("sat_pnz2", 32'(bus.pend_nz), 3);
    chk("sat_flags", 32'(bus.flags), 4'b0100);

    // condex=0 retire plus a CV writer
    idle();
    wb(2'b10, 1'b0, 4'b1111);
    dec(4'b1110, 2'b01);
    #1 chk("cx0_fwd", 32'(bus.flags_fwd), 4'b0100);
    step();
    chk("cx0_flags", 32'(bus.flags), 4'b0100);
    chk("cx0_pnz", 32'(bus.pend_nz), 2);
    chk("cx0_pcv", 32'(bus.pend_cv), 1);

    // flush with an older writeback
    idle();
    bus.flush = 1'b1;
    wb(2'b11, 1'b1, 4'b1001);
    dec(4'b1110, 2'b11);
    #1 chk("fl_issue", 32'(bus.issue_d), 0);
    chk("fl_stall", 32'(bus.stall_d), 0);
    step();
    chk("fl_pnz", 32'(bus.pend_nz), 0);
    chk("fl_pcv", 32'(bus.pend_cv), 0);
    chk("fl_flags", 32'(bus.flags), 4'b1001);
    chk("fl_err", 32'(bus.pend_err), 0);

    // underflow on CV
    idle();
    wb(2'b01, 1'b1, 4'b0011);
    step();
    chk("uf_pcv", 32'(bus.pend_cv), 0);
    chk("uf_err", 32'(bus.pend_err), 1);
    chk("uf_flags", 32'(bus.flags), 4'b1011);
    idle();
    dec(4'b1110, 2'b11);
    step();
    idle();
    step();
    chk("uf_sticky", 32'(bus.pend_err), 1);
    chk("mid_pnz", 32'(bus.pend_nz), 1);

    // asynchronous reset mid-operation
    #2 reset_n = 1'b0;
    #1;
    chk("ar_err", 32'(bus.pend_err), 0);
    chk("ar_pnz", 32'(bus.pend_nz), 0);
    chk("ar_pcv", 32'(bus.pend_cv), 0);
    chk("ar_flags", 32'(bus.flags), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
